// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) round-robin arbiter in front of a single SPI memory controller.
// Latency: 1 IDLE grant cycle + ISSUE (until mem_done or watchdog) + 1 RELEASE cycle; losers simply wait with req held.
module mem_bus_arbiter #(
    parameter int ADDRESS_SIZE   = 18,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    if_req,
    input  logic [ADDRESS_SIZE-1:0] if_addr,
    output logic                    if_done,

    input  logic                    d_req,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic                    d_is_write,
    input  logic [2:0]              d_num_bytes,
    input  logic                    d_is_peripheral,
    input  logic [7:0]              d_periph_tx,
    input  logic [31:0]             d_wdata,
    output logic                    d_done,

    output logic [31:0]             rdata,
    output logic                    err,

    output logic                    mem_start,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic                    mem_is_write,
    output logic [2:0]              mem_num_bytes,
    output logic                    mem_is_peripheral,
    output logic [7:0]              mem_periph_tx,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_done,
    input  logic [31:0]             mem_rdata,

    output logic                    busy,
    output logic                    grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Watchdog value seen during the last permitted ISSUE cycle.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_last_grant;
    logic                    r_grant_d;
    logic                    r_mem_start;
    logic [7:0]              r_wdog;
    logic [31:0]             r_rdata;
    logic                    r_err;

    logic [ADDRESS_SIZE-1:0] r_mem_addr;
    logic                    r_mem_is_write;
    logic [2:0]              r_mem_num_bytes;
    logic                    r_mem_is_peripheral;
    logic [7:0]              r_mem_periph_tx;
    logic [31:0]             r_mem_wdata;

    logic                    w_grant;
    logic                    w_grant_data;
    logic                    w_done_hit;
    logic                    w_timeout;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_data = 1'b0;
        w_done_hit   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_grant      = 1'b1;
                    // On a tie the side that did not own the bus last time wins.
                    w_grant_data = d_req && (!if_req || !r_last_grant);
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_done) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (r_wdog >= WDOG_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= IDLE;
            r_last_grant        <= 1'b1;
            r_grant_d           <= 1'b0;
            r_mem_start         <= 1'b0;
            r_wdog              <= 8'd0;
            r_rdata             <= 32'd0;
            r_err               <= 1'b0;
            r_mem_addr          <= '0;
            r_mem_is_write      <= 1'b0;
            r_mem_num_bytes     <= 3'd0;
            r_mem_is_peripheral <= 1'b0;
            r_mem_periph_tx     <= 8'd0;
            r_mem_wdata         <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_start <= (w_state_nxt == ISSUE);

            if (w_grant) begin
                r_grant_d           <= w_grant_data;
                r_wdog              <= 8'd0;
                r_mem_addr          <= w_grant_data ? d_addr : if_addr;
                r_mem_is_write      <= w_grant_data & d_is_write;
                r_mem_num_bytes     <= w_grant_data ? d_num_bytes : 3'd4;
                r_mem_is_peripheral <= w_grant_data & d_is_peripheral;
                r_mem_periph_tx     <= w_grant_data ? d_periph_tx : 8'd0;
                r_mem_wdata         <= w_grant_data ? d_wdata : 32'd0;
            end else if (r_state == ISSUE && r_wdog != 8'hFF) begin
                r_wdog <= r_wdog + 8'd1;
            end

            if (w_done_hit) begin
                r_rdata <= mem_rdata;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end

            if (r_state == RELEASE) begin
                r_last_grant <= r_grant_d;
            end
        end
    end

    assign if_done           = (r_state == RELEASE) && !r_grant_d;
    assign d_done            = (r_state == RELEASE) &&  r_grant_d;
    assign busy              = (r_state != IDLE);
    assign grant_d           = r_grant_d;
    assign rdata             = r_rdata;
    assign err               = r_err;
    assign mem_start         = r_mem_start;
    assign mem_addr          = r_mem_addr;
    assign mem_is_write      = r_mem_is_write;
    assign mem_num_bytes     = r_mem_num_bytes;
    assign mem_is_peripheral = r_mem_is_peripheral;
    assign mem_periph_tx     = r_mem_periph_tx;
    assign mem_wdata         = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table plus round-robin, reset and stray-done sequences.
// Completions are scored against a queue of expected {owner, rdata, err} entries.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_done;
    logic        d_req;
    logic [17:0] d_addr;
    logic        d_is_write;
    logic [2:0]  d_num_bytes;
    logic        d_is_peripheral;
    logic [7:0]  d_periph_tx;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_start;
    logic [17:0] mem_addr;
    logic        mem_is_write;
    logic [2:0]  mem_num_bytes;
    logic        mem_is_peripheral;
    logic [7:0]  mem_periph_tx;
    logic [31:0] mem_wdata;
    logic        mem_done = 1'b0;
    logic        busy;
    logic        grant_d;

    int          ctrl_lat;
    logic [31:0] ctrl_rdata;
    int          ctrl_cnt = 0;
    logic        stray;

    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        is_d;
        logic [17:0] addr;
        logic        wr;
        logic [2:0]  nb;
        logic        per;
        logic [7:0]  tx;
        logic [31:0] wd;
        int          lat;
        logic [31:0] crd;
        logic [62:0] exp_mem;
        int          exp_len;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDRESS_SIZE  (18),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_done          (if_done),
        .d_req            (d_req),
        .d_addr           (d_addr),
        .d_is_write       (d_is_write),
        .d_num_bytes      (d_num_bytes),
        .d_is_peripheral  (d_is_peripheral),
        .d_periph_tx      (d_periph_tx),
        .d_wdata          (d_wdata),
        .d_done           (d_done),
        .rdata            (rdata),
        .err              (err),
        .mem_start        (mem_start),
        .mem_addr         (mem_addr),
        .mem_is_write     (mem_is_write),
        .mem_num_bytes    (mem_num_bytes),
        .mem_is_peripheral(mem_is_peripheral),
        .mem_periph_tx    (mem_periph_tx),
        .mem_wdata        (mem_wdata),
        .mem_done         (mem_done),
        .mem_rdata        (ctrl_rdata),
        .busy             (busy),
        .grant_d          (grant_d)
    );

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Controller model: answers on the ctrl_lat-th cycle of mem_start (0 = never).
    always @(negedge clk) begin
        if (mem_start) begin
            ctrl_cnt = ctrl_cnt + 1;
            mem_done = ((ctrl_lat != 0) && (ctrl_cnt == ctrl_lat)) || stray;
        end else begin
            ctrl_cnt = 0;
            mem_done = stray;
        end
    end

    always @(negedge clk) begin
        if (if_done || d_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done if_done=%0b d_done=%0b exp=none", if_done, d_done);
            end else begin
                mon_e = sb.pop_front();
                check("done_pulse", {62'd0, if_done, d_done, err, rdata},
                      {62'd0, !mon_e.owner, mon_e.owner, mon_e.err, mon_e.rdata});
            end
        end
    end

    task automatic wait_busy(input string name);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < 8);
        check(name, {95'd0, busy}, 96'd1);
    endtask

    task automatic wait_issue_end(output int n);
        n = 0;
        while (mem_start && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        if_req          = !v.is_d;
        d_req           = v.is_d;
        if_addr         = v.is_d ? ~v.addr : v.addr;
        d_addr          = v.is_d ? v.addr : ~v.addr;
        d_is_write      = v.wr;
        d_num_bytes     = v.nb;
        d_is_peripheral = v.per;
        d_periph_tx     = v.tx;
        d_wdata         = v.wd;
        ctrl_lat        = v.lat;
        ctrl_rdata      = v.crd;
        sb.push_back('{owner: v.is_d, rdata: v.exp_rdata, err: v.exp_err});
        wait_busy("vec_grant");
        check("vec_grant_fields", {31'd0, grant_d, mem_start,
              mem_addr, mem_is_write, mem_num_bytes, mem_is_peripheral, mem_periph_tx, mem_wdata},
              {31'd0, v.is_d, 1'b1, v.exp_mem});
        if_addr         = 18'($urandom);
        d_addr          = 18'($urandom);
        d_is_write      = ~d_is_write;
        d_num_bytes     = 3'($urandom);
        d_is_peripheral = ~d_is_peripheral;
        d_periph_tx     = 8'($urandom);
        d_wdata         = $urandom;
        wait_issue_end(n);
        check("vec_issue_len", 96'(n), 96'(v.exp_len));
        check("vec_fields_stable", {33'd0,
              mem_addr, mem_is_write, mem_num_bytes, mem_is_peripheral, mem_periph_tx, mem_wdata},
              {33'd0, v.exp_mem});
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        check("vec_idle_hold", {61'd0, busy, mem_start, err, rdata},
              {61'd0, 1'b0, 1'b0, v.exp_err, v.exp_rdata});
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 18'h00104, 1'b1, 3'd2, 1'b1, 8'h5A, 32'hFFFF_FFFF, 72, 32'hDEAD_BEEF,
                    {18'h00104, 1'b0, 3'd4, 1'b0, 8'h00, 32'h0000_0000}, 72, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 18'h20010, 1'b1, 3'd2, 1'b0, 8'h00, 32'h0000_ABCD, 5, 32'h1234_5678,
                    {18'h20010, 1'b1, 3'd2, 1'b0, 8'h00, 32'h0000_ABCD}, 5, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 18'h3FFFF, 1'b0, 3'd1, 1'b1, 8'hA5, 32'h0000_0000, 1, 32'h0000_00C3,
                    {18'h3FFFF, 1'b0, 3'd1, 1'b1, 8'hA5, 32'h0000_0000}, 1, 1'b0, 32'h0000_00C3};
        vecs[3] = '{1'b0, 18'h00000, 1'b1, 3'd1, 1'b1, 8'h33, 32'h8765_4321, 0, 32'h7777_7777,
                    {18'h00000, 1'b0, 3'd4, 1'b0, 8'h00, 32'h0000_0000}, 200, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b1, 18'h10000, 1'b0, 3'd4, 1'b0, 8'h00, 32'h0000_0000, 200, 32'hCAFE_F00D,
                    {18'h10000, 1'b0, 3'd4, 1'b0, 8'h00, 32'h0000_0000}, 200, 1'b0, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 18'h1FFFC, 1'b1, 3'd4, 1'b1, 8'hFF, 32'h1111_2222, 3, 32'h0BAD_F00D,
                    {18'h1FFFC, 1'b0, 3'd4, 1'b0, 8'h00, 32'h0000_0000}, 3, 1'b0, 32'h0BAD_F00D};

        rst_n           = 1'b0;
        stray           = 1'b0;
        ctrl_lat        = 3;
        ctrl_rdata      = 32'h5555_AAAA;
        if_req          = 1'b1;
        d_req           = 1'b1;
        if_addr         = 18'h00200;
        d_addr          = 18'h30000;
        d_is_write      = 1'b0;
        d_num_bytes     = 3'd4;
        d_is_peripheral = 1'b0;
        d_periph_tx     = 8'h00;
        d_wdata         = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {32'd0, busy, mem_start, if_done, d_done, err, grant_d,
              mem_addr, mem_is_write, mem_num_bytes, mem_is_peripheral, mem_periph_tx, mem_wdata}, 96'd0);
        check("reset_rdata", {64'd0, rdata}, 96'd0);

        // Both requesters held high: grants must alternate starting with fetch.
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{owner: k[0], rdata: 32'h5555_AAAA, err: 1'b0});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy("alt_grant");
            check("alt_owner", {95'd0, grant_d}, {95'd0, k[0]});
            check("alt_addr", {78'd0, mem_addr}, {78'd0, (k[0] ? 18'h30000 : 18'h00200)});
            wait_issue_end(n);
            check("alt_issue_len", 96'(n), 96'd3);
            if (k == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        @(negedge clk);
        check("alt_idle", {94'd0, busy, mem_start}, 96'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // mem_done while idle must not start anything or produce a completion.
        stray = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_done_idle", {93'd0, busy, mem_start, err}, 96'd0);
        stray = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access: no completion, back to idle at once.
        ctrl_lat = 0;
        if_addr  = 18'h00ABC;
        if_req   = 1'b1;
        wait_busy("rst_mid_grant");
        repeat (10) @(negedge clk);
        rst_n  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check("rst_mid_issue", {58'd0, mem_start, busy, if_done, d_done, err, rdata, 1'b0},
              {58'd0, 38'd0});
        rst_n = 1'b1;
        run_vec(vecs[5]);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 96'(sb.size()), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 18, the memory address width (flash/RAM select bit plus 16-bit byte address plus one extra bit).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200, the maximum number of cycles in ISSUE (range 1..255).
REQ-003 One clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-004 clk  in  1  system clock; all state changes on posedge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 if_req  in  1  instruction-fetch request, level; read of 4 bytes.
REQ-007 if_addr  in  ADDRESS_SIZE  fetch address.
REQ-008 if_done  out  1  one-cycle completion pulse for fetch.
REQ-009 d_req  in  1  data request, level.
REQ-010 d_addr  in  ADDRESS_SIZE  data address.
REQ-011 d_is_write  in  1  1 = write, 0 = read.
REQ-012 d_num_bytes  in  3  access size: 1, 2 or 4.
REQ-013 d_is_peripheral  in  1  peripheral (16-clock) transfer.
REQ-014 d_periph_tx  in  8  peripheral tx byte.
REQ-015 d_wdata  in  32  write data.
REQ-016 d_done  out  1  one-cycle completion pulse for data.
REQ-017 rdata  out  32  read result; valid while either done pulse is high.
REQ-018 err  out  1  high with the done pulse when the access timed out.
REQ-019 mem_start  out  1  start_request to the SPI memory controller, level.
REQ-020 The signals mem_addr, mem_is_write, mem_num_bytes, mem_is_peripheral, mem_periph_tx and mem_wdata SHALL be outputs that mirror the latched request fields.
REQ-021 mem_done  in  1  request_done from the controller.
REQ-022 mem_rdata  in  32  fetched_value from the controller.
REQ-023 busy  out  1  state is not IDLE.
REQ-024 grant_d  out  1  latched owner: 0 = fetch, 1 = data.

Function
REQ-025 SHALL use three states: IDLE, ISSUE and RELEASE.
REQ-026 IDLE with no request: SHALL remain in IDLE with mem_start at 0.
REQ-027 IDLE with exactly one request: SHALL grant that requester, latch its fields into the mem_* registers and go to ISSUE on the same edge.
REQ-028 IDLE with both requests: SHALL grant the requester that was not granted last (round-robin on last_grant); after reset, fetch wins.
REQ-029 Fetch grants SHALL drive mem_is_write=0, mem_num_bytes=4, mem_is_peripheral=0, mem_wdata=0 and mem_periph_tx=0.
REQ-030 mem_start SHALL be registered and SHALL be 1 exactly while in ISSUE, starting the cycle after the grant edge.
REQ-031 mem_* field outputs SHALL remain stable from the grant edge until the next grant, regardless of requester input changes.
REQ-032 ISSUE with mem_done=1 at an edge: SHALL latch rdata from mem_rdata, set err=0 and go to RELEASE.
REQ-033 ISSUE with a watchdog count of TIMEOUT_CYCLES reached: SHALL set rdata=0 and err=1, then go to RELEASE.
REQ-034 If mem_done and the timeout occur on the same edge, mem_done SHALL take priority.
REQ-035 RELEASE SHALL last exactly one cycle with mem_start=0, guaranteeing the controller returns idle.
REQ-036 In RELEASE, the owner's done pulse SHALL be 1 and the other done SHALL be 0.
REQ-037 RELEASE SHALL always go to IDLE; last_grant SHALL be updated to the owner at that transition.
REQ-038 The watchdog counter SHALL be 8 bits, cleared on grant, and SHALL increment each ISSUE cycle without wrap.
REQ-039 A requester SHALL deassert its req at the edge where it samples its done pulse; a req still high in IDLE is a new request.
REQ-040 Minimum turnaround SHALL be 1 cycle (IDLE) + ISSUE length + 1 cycle (RELEASE).
REQ-041 Both requesters asserting continuously SHALL alternate grants: fetch, data, fetch, and so on.
REQ-042 mem_done while in IDLE or RELEASE SHALL be ignored.
REQ-043 rdata and err SHALL hold their last values outside RELEASE.

Reset
REQ-044 rst_n=0 at a posedge SHALL force IDLE, mem_start=0, if_done=0, d_done=0, err=0, rdata=0, all mem_* fields=0, grant_d=0, last_grant=data and watchdog=0.
REQ-045 Reset asserted mid-ISSUE SHALL drop mem_start on the next edge without issuing a done pulse.

Verification
REQ-046 Fetch only, if_addr=0x00104, controller model answers mem_done after 72 cycles with 0xDEADBEEF -> mem_start high for 72 cycles, if_done pulses once with rdata=0xDEADBEEF and err=0, mem_start low exactly 1 cycle.
REQ-047 Both requesters asserted together from reset -> first grant is fetch (grant_d=0); on re-request, the data requester is granted next, and the pattern alternates for 4 transactions.
REQ-048 Data write, d_num_bytes=2, d_wdata=0x0000ABCD, d_addr=0x20010 -> mem_is_write=1, mem_num_bytes=2, mem_addr=0x20010, and d_done pulses once.
REQ-049 Controller never asserts mem_done, TIMEOUT_CYCLES=200 -> after 200 ISSUE cycles, the owner's done=1, err=1, rdata=0; the arbiter returns to IDLE.
REQ-050 rst_n driven low during ISSUE -> next edge gives mem_start=0, busy=0 and no done pulse; a new if_req after reset is granted normally.
REQ-051 Data requester changes d_addr during ISSUE -> mem_addr keeps the latched value until RELEASE.
